// File: rtl/dmem_responder.sv
// dmem_responder: single-port data memory behind a valid/ready request interface.
// Stores and rejected requests answer one cycle after acceptance. Loads answer
// two cycles after acceptance with the selected lane sign- or zero-extended.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        mem_w,
   input  logic [31:0] Addr_in,
   input  logic [31:0] Data_in,
   input  logic [2:0]  dm_ctrl,
   output logic        rsp_valid,
   output logic [31:0] Data_out,
   output logic        err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      READ = 2'b01,
      RESP = 2'b10
   } state_t;

   // A request is rejected for a reserved size code or a misaligned address.
   function automatic logic is_bad_req(input logic [2:0] ctrl, input logic [1:0] off);
      logic bad;
      case (ctrl)
         3'b000:         bad = (off != 2'b00);
         3'b001, 3'b010: bad = off[0];
         3'b011, 3'b100: bad = 1'b0;
         default:        bad = 1'b1;
      endcase
      return bad;
   endfunction

   // Byte lanes touched by a store of the given size at the given offset.
   function automatic logic [3:0] byte_en(input logic [2:0] ctrl, input logic [1:0] off);
      logic [3:0] be;
      case (ctrl)
         3'b000:         be = 4'b1111;
         3'b001, 3'b010: be = off[1] ? 4'b1100 : 4'b0011;
         3'b011, 3'b100: be = 4'b0001 << off;
         default:        be = 4'b0000;
      endcase
      return be;
   endfunction

   // Replicate the low byte/half across the word so any enabled lane sees it.
   function automatic logic [31:0] store_lanes(input logic [2:0] ctrl, input logic [31:0] data);
      logic [31:0] w;
      case (ctrl)
         3'b001, 3'b010: w = {2{data[15:0]}};
         3'b011, 3'b100: w = {4{data[7:0]}};
         default:        w = data;
      endcase
      return w;
   endfunction

   // Pick the addressed lane out of a RAM word and extend it to 32 bits.
   function automatic logic [31:0] load_extend(input logic [31:0] word,
                                               input logic [2:0]  ctrl,
                                               input logic [1:0]  off);
      logic [15:0] half_v;
      logic [7:0]  byte_v;
      logic [31:0] res;
      half_v = off[1] ? word[31:16] : word[15:0];
      case (off)
         2'b00:   byte_v = word[7:0];
         2'b01:   byte_v = word[15:8];
         2'b10:   byte_v = word[23:16];
         2'b11:   byte_v = word[31:24];
         default: byte_v = word[7:0];
      endcase
      case (ctrl)
         3'b000:  res = word;
         3'b001:  res = {{16{half_v[15]}}, half_v};
         3'b010:  res = {16'h0000, half_v};
         3'b011:  res = {{24{byte_v[7]}}, byte_v};
         3'b100:  res = {24'h000000, byte_v};
         default: res = 32'h0000_0000;
      endcase
      return res;
   endfunction

   state_t          state_r;
   state_t          state_next_s;

   logic [31:0]     mem_r [0:DEPTH_WORDS-1];

   logic            accept_s;
   logic            bad_s;
   logic            wr_en_s;
   logic [3:0]      be_s;
   logic [31:0]     wdata_s;
   logic [AW-1:0]   idx_s;

   logic [AW-1:0]   rd_idx_r;
   logic [2:0]      rd_ctrl_r;
   logic [1:0]      rd_off_r;

   logic            ready_r;
   logic            rsp_valid_r;
   logic            err_r;
   logic [31:0]     data_out_r;

   // Address bits above the RAM window are deliberately ignored (wrap-around).
   logic            unused_addr_s;
   assign unused_addr_s = ^Addr_in[31:AW+2];

   // Decode the incoming request: word index, legality, lanes and acceptance.
   always_comb begin
      idx_s   = Addr_in[AW+1:2];
      bad_s   = is_bad_req(dm_ctrl, Addr_in[1:0]);
      be_s    = byte_en(dm_ctrl, Addr_in[1:0]);
      wdata_s = store_lanes(dm_ctrl, Data_in);
      if ((state_r == IDLE) && req_valid && !reset) begin
         accept_s = 1'b1;
      end else begin
         accept_s = 1'b0;
      end
      wr_en_s = accept_s & mem_w & ~bad_s;
   end

   // Next-state logic: loads take the extra READ cycle, everything else goes to RESP.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (bad_s || mem_w) begin
                  state_next_s = RESP;
               end else begin
                  state_next_s = READ;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         READ:    state_next_s = RESP;
         RESP:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Capture the load parameters at acceptance; they are used in the READ cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_idx_r  <= '0;
         rd_ctrl_r <= 3'b000;
         rd_off_r  <= 2'b00;
      end else if (accept_s) begin
         rd_idx_r  <= idx_s;
         rd_ctrl_r <= dm_ctrl;
         rd_off_r  <= Addr_in[1:0];
      end
   end

   // RAM write port with byte enables; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         for (int b = 0; b < 4; b++) begin
            if (be_s[b]) begin
               mem_r[idx_s][b*8 +: 8] <= wdata_s[b*8 +: 8];
            end
         end
      end
   end

   // Registered outputs: response fields are zero outside the response cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         ready_r     <= 1'b1;
         rsp_valid_r <= 1'b0;
         err_r       <= 1'b0;
         data_out_r  <= 32'h0000_0000;
      end else begin
         ready_r     <= (state_next_s == IDLE);
         rsp_valid_r <= (state_next_s == RESP);
         err_r       <= accept_s & bad_s;
         if (state_r == READ) begin
            data_out_r <= load_extend(mem_r[rd_idx_r], rd_ctrl_r, rd_off_r);
         end else begin
            data_out_r <= 32'h0000_0000;
         end
      end
   end

   assign req_ready = ready_r;
   assign rsp_valid = rsp_valid_r;
   assign err       = err_r;
   assign Data_out  = data_out_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: expected responses are queued when a
// request is driven and compared when the response appears.
module tb_dmem_responder;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        mem_w;
   logic [31:0] Addr_in;
   logic [31:0] Data_in;
   logic [2:0]  dm_ctrl;
   logic        rsp_valid;
   logic [31:0] Data_out;
   logic        err;

   int checks = 0;
   int passes = 0;

   // expected {err, data}
   logic [32:0] exp_q[$];
   logic [31:0] ref_mem [0:255];

   dmem_responder #(.DEPTH_WORDS(256)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .mem_w(mem_w), .Addr_in(Addr_in), .Data_in(Data_in), .dm_ctrl(dm_ctrl),
      .rsp_valid(rsp_valid), .Data_out(Data_out), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference result of a request against the model memory.
   function automatic logic [32:0] exp_of(input logic mw, input logic [31:0] a, input logic [2:0] c);
      logic [31:0] w;
      logic [31:0] sh;
      logic        bad;
      bad = (c > 3'd4) || (c == 3'd0 && a[1:0] != 2'b00) || ((c == 3'd1 || c == 3'd2) && a[0]);
      if (bad) return {1'b1, 32'h0};
      if (mw) return {1'b0, 32'h0};
      w = ref_mem[a[9:2]];
      case (c)
         3'd1: begin sh = w >> {a[1], 4'b0000}; return {1'b0, {{16{sh[15]}}, sh[15:0]}}; end
         3'd2: begin sh = w >> {a[1], 4'b0000}; return {1'b0, 16'h0000, sh[15:0]}; end
         3'd3: begin sh = w >> {a[1:0], 3'b000}; return {1'b0, {{24{sh[7]}}, sh[7:0]}}; end
         3'd4: begin sh = w >> {a[1:0], 3'b000}; return {1'b0, 24'h000000, sh[7:0]}; end
         default: return {1'b0, w};
      endcase
   endfunction

   // Apply a legal store to the model memory.
   task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
      case (c)
         3'd0: ref_mem[a[9:2]] = d;
         3'd1, 3'd2: ref_mem[a[9:2]][{a[1], 4'b0000} +: 16] = d[15:0];
         3'd3, 3'd4: ref_mem[a[9:2]][{a[1:0], 3'b000} +: 8] = d[7:0];
         default: ;
      endcase
   endtask

   // Drive one request and collect {latency, quiet, err, Data_out}. quiet is 1
   // when outputs stayed zero before the response and req_ready stayed low.
   // With hold=1 req_valid stays high (with different fields) through the
   // response cycle; the task then returns in the following cycle.
   task automatic do_req(input logic mw, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] c, input bit hold, output logic [37:0] obs);
      int   guard;
      int   lat;
      logic q;
      guard = 0;
      while (req_ready !== 1'b1 && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      req_valid = 1'b1; mem_w = mw; Addr_in = a; Data_in = d; dm_ctrl = c;
      @(posedge clk); #1;
      if (hold) begin
         Addr_in = a ^ 32'h4; Data_in = ~d; mem_w = 1'b1; dm_ctrl = 3'b000;
      end else begin
         req_valid = 1'b0;
      end
      lat = 1; q = 1'b1;
      while (rsp_valid !== 1'b1 && lat < 10) begin
         if (err !== 1'b0 || Data_out !== 32'h0 || req_ready !== 1'b0) q = 1'b0;
         @(posedge clk); #1; lat++;
      end
      if (req_ready !== 1'b0) q = 1'b0;
      obs = {lat[3:0], q, err, Data_out};
      if (hold) begin
         @(posedge clk); #1; req_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; req_valid = 1'b0; mem_w = 1'b0; Addr_in = 32'h0; Data_in = 32'h0; dm_ctrl = 3'b000;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({rsp_valid, err, Data_out} !== 34'h0) $display("FAIL reset_hold: got %h want 0", {rsp_valid, err, Data_out});
      else passes++;
      reset = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({req_ready, rsp_valid, err, Data_out} !== {1'b1, 34'h0})
         $display("FAIL reset_release: got %h want %h", {req_ready, rsp_valid, err, Data_out}, {1'b1, 34'h0});
      else passes++;
   endtask

   task automatic test_word();
      logic [37:0] obs;
      logic [32:0] e;
      exp_q.push_back({1'b0, 32'h0});
      do_req(1'b1, 32'h10, 32'hDEADBEEF, 3'b000, 1'b0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== {4'd1, 1'b1, e}) $display("FAIL store_word: got %h want %h", obs, {4'd1, 1'b1, e});
      else passes++;
      exp_q.push_back({1'b0, 32'hDEADBEEF});
      do_req(1'b0, 32'h10, 32'h0, 3'b000, 1'b0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== {4'd2, 1'b1, e}) $display("FAIL load_word: got %h want %h", obs, {4'd2, 1'b1, e});
      else passes++;
   endtask

   task automatic test_subword();
      logic [31:0] addr_t [4] = '{32'h13, 32'h13, 32'h10, 32'h12};
      logic [2:0]  ctrl_t [4] = '{3'b011, 3'b100, 3'b001, 3'b010};
      logic [31:0] exp_t  [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFBEEF, 32'h0000DEAD};
      logic [37:0] obs;
      logic [32:0] e;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back({1'b0, exp_t[i]});
         do_req(1'b0, addr_t[i], 32'h0, ctrl_t[i], 1'b0, obs);
         e = exp_q.pop_front();
         checks++;
         if (obs !== {4'd2, 1'b1, e}) $display("FAIL subword_load_%0d: got %h want %h", i, obs, {4'd2, 1'b1, e});
         else passes++;
      end
   endtask

   task automatic test_byte_store();
      logic [37:0] obs;
      logic [32:0] e;
      exp_q.push_back({1'b0, 32'h0});
      do_req(1'b1, 32'h11, 32'h1234565A, 3'b011, 1'b0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== {4'd1, 1'b1, e}) $display("FAIL store_byte: got %h want %h", obs, {4'd1, 1'b1, e});
      else passes++;
      exp_q.push_back({1'b0, 32'hDEAD5AEF});
      do_req(1'b0, 32'h10, 32'h0, 3'b000, 1'b0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== {4'd2, 1'b1, e}) $display("FAIL byte_merge: got %h want %h", obs, {4'd2, 1'b1, e});
      else passes++;
   endtask

   task automatic test_errors();
      logic        mw_t   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
      logic [31:0] addr_t [4] = '{32'h12, 32'h13, 32'h10, 32'h10};
      logic [2:0]  ctrl_t [4] = '{3'b000, 3'b001, 3'b101, 3'b000};
      logic [32:0] exp_t  [4] = '{{1'b1, 32'h0}, {1'b1, 32'h0}, {1'b1, 32'h0}, {1'b0, 32'hDEAD5AEF}};
      logic [3:0]  lat_t  [4] = '{4'd1, 4'd1, 4'd1, 4'd2};
      logic [37:0] obs;
      logic [32:0] e;
      for (int i = 0; i < 4; i++) begin
         exp_q.push_back(exp_t[i]);
         do_req(mw_t[i], addr_t[i], 32'hFFFF_FFFF, ctrl_t[i], 1'b0, obs);
         e = exp_q.pop_front();
         checks++;
         if (obs !== {lat_t[i], 1'b1, e}) $display("FAIL error_case_%0d: got %h want %h", i, obs, {lat_t[i], 1'b1, e});
         else passes++;
      end
   endtask

   task automatic test_back_to_back();
      logic [37:0] obs;
      logic [32:0] e;
      exp_q.push_back({1'b0, 32'h0});
      do_req(1'b1, 32'h24, 32'h0, 3'b000, 1'b0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== {4'd1, 1'b1, e}) $display("FAIL clear_24: got %h want %h", obs, {4'd1, 1'b1, e});
      else passes++;
      exp_q.push_back({1'b0, 32'h0});
      do_req(1'b1, 32'h20, 32'hCAFEF00D, 3'b000, 1'b1, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== {4'd1, 1'b1, e}) $display("FAIL held_store: got %h want %h", obs, {4'd1, 1'b1, e});
      else passes++;
      checks++;
      if ({req_ready, rsp_valid} !== 2'b10) $display("FAIL no_duplicate: got %b want 10", {req_ready, rsp_valid});
      else passes++;
      exp_q.push_back({1'b0, 32'hCAFEF00D});
      do_req(1'b0, 32'h20, 32'h0, 3'b000, 1'b0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== {4'd2, 1'b1, e}) $display("FAIL load_after_store: got %h want %h", obs, {4'd2, 1'b1, e});
      else passes++;
      exp_q.push_back({1'b0, 32'h0});
      do_req(1'b0, 32'h24, 32'h0, 3'b000, 1'b0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== {4'd2, 1'b1, e}) $display("FAIL busy_inputs_ignored: got %h want %h", obs, {4'd2, 1'b1, e});
      else passes++;
   endtask

   task automatic test_reset_mid();
      logic [37:0] obs;
      logic [32:0] e;
      int          guard;
      logic        seen;
      guard = 0;
      while (req_ready !== 1'b1 && guard < 20) begin @(posedge clk); #1; guard++; end
      // load aborted by reset in its READ cycle
      req_valid = 1'b1; mem_w = 1'b0; Addr_in = 32'h10; dm_ctrl = 3'b000;
      @(posedge clk); #1;
      req_valid = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if ({req_ready, rsp_valid} !== 2'b10) $display("FAIL ready_after_reset: got %b want 10", {req_ready, rsp_valid});
      else passes++;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid !== 1'b0) seen = 1'b1;
         @(posedge clk); #1;
      end
      checks++;
      if (seen !== 1'b0) $display("FAIL aborted_load_rsp: got %b want 0", seen);
      else passes++;
      // store accepted, then reset in its response cycle: data must stay written
      req_valid = 1'b1; mem_w = 1'b1; Addr_in = 32'h28; Data_in = 32'h12345678; dm_ctrl = 3'b000;
      @(posedge clk); #1;
      req_valid = 1'b0; reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      // request presented together with reset must be ignored
      reset = 1'b1; req_valid = 1'b1; mem_w = 1'b1; Addr_in = 32'h24; Data_in = 32'hBAD0BAD0;
      @(posedge clk); #1;
      reset = 1'b0; req_valid = 1'b0;
      checks++;
      if ({req_ready, rsp_valid} !== 2'b10) $display("FAIL req_during_reset: got %b want 10", {req_ready, rsp_valid});
      else passes++;
      exp_q.push_back({1'b0, 32'h12345678});
      do_req(1'b0, 32'h28, 32'h0, 3'b000, 1'b0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== {4'd2, 1'b1, e}) $display("FAIL store_survives_reset: got %h want %h", obs, {4'd2, 1'b1, e});
      else passes++;
      exp_q.push_back({1'b0, 32'h0});
      do_req(1'b0, 32'h24, 32'h0, 3'b000, 1'b0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== {4'd2, 1'b1, e}) $display("FAIL reset_req_not_written: got %h want %h", obs, {4'd2, 1'b1, e});
      else passes++;
   endtask

   task automatic test_wrap();
      logic [37:0] obs;
      logic [32:0] e;
      exp_q.push_back({1'b0, 32'h0});
      do_req(1'b1, 32'h400, 32'h11111111, 3'b000, 1'b0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== {4'd1, 1'b1, e}) $display("FAIL wrap_store: got %h want %h", obs, {4'd1, 1'b1, e});
      else passes++;
      exp_q.push_back({1'b0, 32'h11111111});
      do_req(1'b0, 32'h000, 32'h0, 3'b000, 1'b0, obs);
      e = exp_q.pop_front();
      checks++;
      if (obs !== {4'd2, 1'b1, e}) $display("FAIL wrap_load: got %h want %h", obs, {4'd2, 1'b1, e});
      else passes++;
   endtask

   task automatic test_random();
      logic [37:0] obs;
      logic [32:0] e;
      logic [31:0] a;
      logic [31:0] d;
      logic [2:0]  c;
      logic        mw;
      logic [3:0]  lat_e;
      for (int i = 0; i < 48; i++) begin
         if (i < 8) begin
            mw = 1'b1; a = 32'h100 + 32'(i * 4); c = 3'b000;
         end else begin
            mw = 1'($urandom_range(0, 1));
            a  = ($urandom() & 32'hFFFF_FC00) | (32'h100 + 32'($urandom_range(0, 31)));
            c  = 3'($urandom_range(0, 7));
         end
         d = $urandom();
         e = exp_of(mw, a, c);
         exp_q.push_back(e);
         if (mw && !e[32]) model_store(a, d, c);
         lat_e = (mw || e[32]) ? 4'd1 : 4'd2;
         do_req(mw, a, d, c, 1'b0, obs);
         e = exp_q.pop_front();
         checks++;
         if (obs !== {lat_e, 1'b1, e})
            $display("FAIL random_%0d mw=%b a=%h c=%0d: got %h want %h", i, mw, a, c, obs, {lat_e, 1'b1, e});
         else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_word();
      test_subword();
      test_byte_store();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
